poly_keygen_fg_ctrl: RTL and testbench

POLY_KEYGEN_FG_CTRL -- requirements
Module: poly_keygen_fg_ctrl

---
 rtl/poly_keygen_fg_ctrl_pkg.sv | 25 ++
 rtl/poly_norm_acc.sv | 41 ++++
 rtl/poly_keygen_fg_ctrl.sv | 134 +++++++++++++
 tb/tb_poly_keygen_fg_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/poly_keygen_fg_ctrl_pkg.sv
// rtl/poly_keygen_fg_ctrl_pkg.sv - shared Falcon keygen types and defaults
//
// Contents:
//   fg_state_t      FSM state encoding for poly_keygen_fg_ctrl
//   DEFAULT_BOUND   exclusive upper limit on ||f||^2 + ||g||^2
//   f_bit_for_logn  signed coefficient width for a given logn
package poly_keygen_fg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN_F = 3'd1,
    ST_GAP   = 3'd2,
    ST_GEN_G = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } fg_state_t;

  localparam int DEFAULT_BOUND = 16823;

  // Falcon-512 needs one more bit of coefficient range than Falcon-1024.
  function automatic int f_bit_for_logn(input int logn);
    return (logn == 9) ? 7 : 6;
  endfunction

endpackage

// File: rtl/poly_norm_acc.sv
// rtl/poly_norm_acc.sv - square-and-accumulate datapath for the (f, g) norm
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear of the accumulator
//   add_en       add sample^2 to the accumulator this cycle
//   sample       signed coefficient, f_bit wide
//   acc          running sum of squares, norm_w wide
module poly_norm_acc #(
  parameter int f_bit  = 7,
  parameter int norm_w = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    add_en,
  input  logic signed [f_bit-1:0] sample,
  output logic [norm_w-1:0]       acc
);

  logic signed [2*f_bit-1:0] sample_ext;
  logic signed [2*f_bit-1:0] square;
  logic [norm_w-1:0]         square_ext;

  // Sign-extend before multiplying so the product is exact; a square is
  // never negative, so zero-extending it to the accumulator width is safe.
  assign sample_ext = (2*f_bit)'(sample);
  assign square     = sample_ext * sample_ext;
  assign square_ext = {{(norm_w-2*f_bit){1'b0}}, square};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + square_ext;
    end
  end

endmodule

// File: rtl/poly_keygen_fg_ctrl.sv
// rtl/poly_keygen_fg_ctrl.sv - (f, g) generation controller with norm rejection
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         one-cycle request / synchronous cancel
//   mk_ena               enable to the small-Gaussian sampler
//   mk_f_valid, mk_f     sampler coefficient stream
//   coef_we, coef_sel,   coefficient RAM write port (sel 0 = f, 1 = g)
//   coef_addr, coef_data
//   busy, done           status; done pulses once per accepted pair
//   norm                 sum of f[i]^2 + g[i]^2
//   retry_cnt            rejected attempts for the current start (saturating)
module poly_keygen_fg_ctrl
  import poly_keygen_fg_ctrl_pkg::*;
#(
  parameter int logn  = 9,
  parameter int f_bit = f_bit_for_logn(logn),
  parameter int BOUND = DEFAULT_BOUND
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    mk_ena,
  input  logic                    mk_f_valid,
  input  logic signed [f_bit-1:0] mk_f,
  output logic                    coef_we,
  output logic                    coef_sel,
  output logic [logn-1:0]         coef_addr,
  output logic signed [f_bit-1:0] coef_data,
  output logic                    busy,
  output logic                    done,
  output logic [2*f_bit+logn:0]   norm,
  output logic [7:0]              retry_cnt
);

  localparam int NORM_W = 2*f_bit + logn + 1;

  fg_state_t       state;
  logic [logn-1:0] counter;
  logic            retry_pend;
  logic            in_gen;
  logic            take;
  logic            last_coef;
  logic            below_bound;
  logic            acc_clr;
  logic [NORM_W-1:0] acc;

  assign in_gen      = (state == ST_GEN_F) || (state == ST_GEN_G);
  // abort wins over a coefficient arriving in the same cycle
  assign take        = in_gen && mk_f_valid && !abort;
  assign last_coef   = &counter;
  assign below_bound = ({1'b0, acc} < (NORM_W+1)'(BOUND));
  assign acc_clr     = !abort && (((state == ST_IDLE) && start) ||
                                  ((state == ST_CHECK) && !below_bound));

  poly_norm_acc #(
    .f_bit  (f_bit),
    .norm_w (NORM_W)
  ) u_norm_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clr),
    .add_en (take),
    .sample (mk_f),
    .acc    (acc)
  );

  assign mk_ena    = in_gen && !abort;
  assign coef_we   = take;
  assign coef_sel  = (state == ST_GEN_G);
  assign coef_addr = counter;
  assign coef_data = take ? mk_f : '0;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) && !abort;
  assign norm      = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      counter    <= '0;
      retry_pend <= 1'b0;
      retry_cnt  <= '0;
    end else if (abort) begin
      state      <= ST_IDLE;
      retry_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            counter    <= '0;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            state      <= ST_GEN_F;
          end
        end
        ST_GEN_F: begin
          if (mk_f_valid) begin
            counter <= counter + 1'b1;
            if (last_coef) state <= ST_GAP;
          end
        end
        ST_GAP: begin
          // One idle sampler cycle between polynomials, reused after a reject.
          if (retry_pend) begin
            retry_pend <= 1'b0;
            state      <= ST_GEN_F;
          end else begin
            state <= ST_GEN_G;
          end
        end
        ST_GEN_G: begin
          if (mk_f_valid) begin
            counter <= counter + 1'b1;
            if (last_coef) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (below_bound) begin
            state <= ST_DONE;
          end else begin
            counter    <= '0;
            retry_cnt  <= (retry_cnt == 8'hff) ? retry_cnt : retry_cnt + 8'd1;
            retry_pend <= 1'b1;
            state      <= ST_GAP;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_keygen_fg_ctrl.sv
// tb/tb_poly_keygen_fg_ctrl.sv - directed self-checking bench for poly_keygen_fg_ctrl
module tb_poly_keygen_fg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, abort, mk_f_valid;
  logic signed [6:0] mk_f;

  logic              u0_mk_ena, u0_coef_we, u0_coef_sel, u0_busy, u0_done;
  logic [8:0]        u0_coef_addr;
  logic signed [6:0] u0_coef_data;
  logic [23:0]       u0_norm;
  logic [7:0]        u0_retry_cnt;

  logic              u1_mk_ena, u1_coef_we, u1_coef_sel, u1_busy, u1_done;
  logic [8:0]        u1_coef_addr;
  logic signed [6:0] u1_coef_data;
  logic [23:0]       u1_norm;
  logic [7:0]        u1_retry_cnt;

  logic              u2_mk_ena, u2_coef_we, u2_coef_sel, u2_busy, u2_done;
  logic [8:0]        u2_coef_addr;
  logic signed [6:0] u2_coef_data;
  logic [23:0]       u2_norm;
  logic [7:0]        u2_retry_cnt;

  poly_keygen_fg_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mk_ena(u0_mk_ena), .mk_f_valid(mk_f_valid), .mk_f(mk_f),
    .coef_we(u0_coef_we), .coef_sel(u0_coef_sel), .coef_addr(u0_coef_addr),
    .coef_data(u0_coef_data), .busy(u0_busy), .done(u0_done),
    .norm(u0_norm), .retry_cnt(u0_retry_cnt)
  );

  poly_keygen_fg_ctrl #(.BOUND(1024)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mk_ena(u1_mk_ena), .mk_f_valid(mk_f_valid), .mk_f(mk_f),
    .coef_we(u1_coef_we), .coef_sel(u1_coef_sel), .coef_addr(u1_coef_addr),
    .coef_data(u1_coef_data), .busy(u1_busy), .done(u1_done),
    .norm(u1_norm), .retry_cnt(u1_retry_cnt)
  );

  poly_keygen_fg_ctrl #(.BOUND(1025)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mk_ena(u2_mk_ena), .mk_f_valid(mk_f_valid), .mk_f(mk_f),
    .coef_we(u2_coef_we), .coef_sel(u2_coef_sel), .coef_addr(u2_coef_addr),
    .coef_data(u2_coef_data), .busy(u2_busy), .done(u2_done),
    .norm(u2_norm), .retry_cnt(u2_retry_cnt)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  int         wf, wg, addr_err, data_err, done0, done1, done2;
  logic [8:0] f_idx, g_idx;
  logic       last_we, last_sel;
  logic [8:0] last_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr_cnt();
    wf = 0; wg = 0; addr_err = 0; data_err = 0;
    done0 = 0; done1 = 0; done2 = 0;
    f_idx = '0; g_idx = '0;
  endtask

  // Drive at the falling edge, observe 4 time units later (1 before the rising edge).
  task automatic step(input logic s, input logic a, input logic v, input logic signed [6:0] d);
    @(negedge clk);
    start = s; abort = a; mk_f_valid = v; mk_f = d;
    #4;
    last_we   = u0_coef_we;
    last_sel  = u0_coef_sel;
    last_addr = u0_coef_addr;
    if (u0_coef_we) begin
      if (u0_coef_data !== d) data_err++;
      if (!u0_coef_sel) begin
        if (u0_coef_addr !== f_idx) addr_err++;
        f_idx++;
        wf++;
      end else begin
        if (u0_coef_addr !== g_idx) addr_err++;
        g_idx++;
        wg++;
      end
    end
    if (u0_done) done0++;
    if (u1_done) done1++;
    if (u2_done) done2++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mk_ena"},    u0_mk_ena, 0);
    check({tag, "_coef_we"},   u0_coef_we, 0);
    check({tag, "_coef_sel"},  u0_coef_sel, 0);
    check({tag, "_coef_addr"}, u0_coef_addr, 0);
    check({tag, "_coef_data"}, u0_coef_data, 0);
    check({tag, "_busy"},      u0_busy, 0);
    check({tag, "_done"},      u0_done, 0);
    check({tag, "_norm"},      u0_norm, 0);
    check({tag, "_retry"},     u0_retry_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mk_f_valid = 1'b1; mk_f = 7'sd3;
    clr_cnt();
    last_we = 1'b0; last_sel = 1'b0; last_addr = '0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1; mk_f_valid = 1'b0;

    // all +1: accepted by default bound and by 1025, rejected by 1024
    clr_cnt();
    step(1, 0, 0, 0);
    for (int i = 0; i < 1100 && done0 == 0; i++) step(0, 0, 1, 7'sd1);
    check("a_done",      done0, 1);
    check("a_f_writes",  wf, 512);
    check("a_g_writes",  wg, 512);
    check("a_addr_err",  addr_err, 0);
    check("a_data_err",  data_err, 0);
    check("a_norm",      u0_norm, 1024);
    check("a_retry",     u0_retry_cnt, 0);
    check("b1025_done",  done2, 1);
    check("b1025_norm",  u2_norm, 1024);
    check("b1024_done",  done1, 0);
    check("b1024_retry", u1_retry_cnt, 1);
    check("b1024_busy",  u1_busy, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("a_idle_busy", u0_busy, 0);
    check("a_one_done",  done0, 1);
    check("a_norm_held", u0_norm, 1024);

    // valid while idle is ignored
    step(0, 1, 0, 0);
    clr_cnt();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 7'sd5);
    check("idle_writes", wf + wg, 0);
    check("idle_norm",   u0_norm, 1024);
    check("idle_u1",     u1_busy, 0);

    // all -4: 16384 passes
    clr_cnt();
    step(1, 0, 0, 0);
    for (int i = 0; i < 1100 && done0 == 0; i++) step(0, 0, 1, -7'sd4);
    check("n4_done",  done0, 1);
    check("n4_norm",  u0_norm, 16384);
    check("n4_retry", u0_retry_cnt, 0);
    check("n4_data",  data_err, 0);
    step(0, 1, 0, 0);

    // all 5: 25600 fails; CHECK then GAP, then f restarts at address 0
    clr_cnt();
    step(1, 0, 0, 0);
    for (int i = 0; i < 1100 && wg < 512; i++) step(0, 0, 1, 7'sd5);
    check("p5_g_writes", wg, 512);
    step(0, 0, 1, 7'sd5);
    check("p5_norm",     u0_norm, 25600);
    check("p5_chk_ena",  u0_mk_ena, 0);
    check("p5_chk_we",   last_we, 0);
    step(0, 0, 1, 7'sd5);
    check("p5_gap_ena",  u0_mk_ena, 0);
    check("p5_gap_we",   last_we, 0);
    check("p5_retry",    u0_retry_cnt, 1);
    check("p5_gap_norm", u0_norm, 0);
    step(0, 0, 1, 7'sd5);
    check("p5_re_ena",   u0_mk_ena, 1);
    check("p5_re_we",    last_we, 1);
    check("p5_re_sel",   last_sel, 0);
    check("p5_re_addr",  last_addr, 0);
    check("p5_done",     done0, 0);
    step(0, 1, 1, 7'sd5);
    check("p5_abort_we", last_we, 0);
    step(0, 0, 0, 0);
    check("p5_abort_busy", u0_busy, 0);

    // abort when g[300] is offered
    clr_cnt();
    step(1, 0, 0, 0);
    for (int i = 0; i < 1100 && wg < 300; i++) step(0, 0, 1, 7'sd1);
    check("ab_g_writes", wg, 300);
    step(0, 1, 1, 7'sd1);
    check("ab_we",      last_we, 0);
    check("ab_ena",     u0_mk_ena, 0);
    step(0, 0, 0, 0);
    check("ab_busy",    u0_busy, 0);
    check("ab_ena_idle", u0_mk_ena, 0);
    check("ab_norm",    u0_norm, 812);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("ab_no_done", done0, 0);
    clr_cnt();
    step(1, 0, 0, 0);
    step(0, 0, 1, 7'sd2);
    check("ab_re_we",   last_we, 1);
    check("ab_re_sel",  last_sel, 0);
    check("ab_re_addr", last_addr, 0);
    check("ab_re_norm", u0_norm, 0);
    step(0, 1, 0, 0);

    // asynchronous reset in the middle of f
    clr_cnt();
    step(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 7'sd3);
    @(negedge clk);
    start = 1'b0; abort = 1'b0; mk_f_valid = 1'b1; mk_f = 7'sd3;
    #2;
    check("rs_pre_we",   u0_coef_we, 1);
    check("rs_pre_addr", u0_coef_addr, 100);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rs_mid");
    @(negedge clk);
    rst_n = 1'b1; mk_f_valid = 1'b0;
    clr_cnt();
    step(1, 0, 0, 0);
    step(0, 0, 1, 7'sd3);
    check("rs_re_we",   last_we, 1);
    check("rs_re_sel",  last_sel, 0);
    check("rs_re_addr", last_addr, 0);
    check("rs_re_norm", u0_norm, 0);
    step(0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
